register_bank: RTL and testbench

REGISTER_BANK -- requirements
Module: register_bank

---
 rtl/register_bank_pkg.sv | 10 +
 rtl/register_bank_if.sv | 35 +++
 rtl/busy_table.sv | 57 +++++
 rtl/register_bank.sv | 77 +++++++
 tb/tb_register_bank.sv | 328 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/register_bank_pkg.sv
// Shared constants for the register bank: default geometry and the index of
// the hard-wired zero register.
package register_bank_pkg;

    localparam int DEFAULT_DATA_WIDTH     = 32;
    localparam int DEFAULT_ADDR_WIDTH     = 5;
    localparam int DEFAULT_NUM_READ_PORTS = 2;
    localparam int ZERO_REG_INDEX         = 0;

endpackage

// File: rtl/register_bank_if.sv
// Bus bundle between a pipeline front end (master) and the register bank (slave).
interface register_bank_if #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 5,
    parameter int NUM_READ_PORTS = 2
);

    logic [NUM_READ_PORTS*ADDR_WIDTH-1:0] read_address;
    logic [NUM_READ_PORTS*DATA_WIDTH-1:0] read_data;
    logic [NUM_READ_PORTS-1:0]            read_ready;
    logic                                 write_enable;
    logic [ADDR_WIDTH-1:0]                write_address;
    logic [DATA_WIDTH-1:0]                write_data;
    // Reservation handshake: reserve_enable is the request, reserve_stall is a
    // combinational refusal. A request with reserve_stall low is accepted on the
    // rising edge; when stalled the master holds the request and retries.
    logic                                 reserve_enable;
    logic [ADDR_WIDTH-1:0]                reserve_address;
    logic                                 reserve_stall;
    logic                                 flush;
    logic [ADDR_WIDTH:0]                  busy_count;

    modport master (
        output read_address, write_enable, write_address, write_data,
               reserve_enable, reserve_address, flush,
        input  read_data, read_ready, reserve_stall, busy_count
    );

    modport slave (
        input  read_address, write_enable, write_address, write_data,
               reserve_enable, reserve_address, flush,
        output read_data, read_ready, reserve_stall, busy_count
    );

endinterface

// File: rtl/busy_table.sv
// Scoreboard of registers with a pending result: reserve/write/flush priority,
// reservation stall and a registered population count of busy bits.
module busy_table
    import register_bank_pkg::*;
#(
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int ZERO_REG   = 1,
    localparam int DEPTH     = 2**ADDR_WIDTH
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  write_enable,
    input  logic [ADDR_WIDTH-1:0] write_address,
    input  logic                  reserve_enable,
    input  logic [ADDR_WIDTH-1:0] reserve_address,
    input  logic                  flush,
    output logic [DEPTH-1:0]      busy,
    output logic                  reserve_stall,
    output logic [ADDR_WIDTH:0]   busy_count
);

    logic [DEPTH-1:0]    busy_next;
    logic [ADDR_WIDTH:0] count_next;

    // A write landing on the reserved register this cycle frees it, so no stall.
    assign reserve_stall = reserve_enable && busy[reserve_address] &&
                           !(write_enable && (write_address == reserve_address));

    always_comb begin
        busy_next = busy;
        if (write_enable)
            busy_next[write_address] = 1'b0;
        if (reserve_enable && !reserve_stall)
            busy_next[reserve_address] = 1'b1;
        if (flush)
            busy_next = '0;
        if (ZERO_REG != 0)
            busy_next[ZERO_REG_INDEX] = 1'b0;
    end

    always_comb begin
        count_next = '0;
        for (int i = 0; i < DEPTH; i++)
            count_next = count_next + {{ADDR_WIDTH{1'b0}}, busy_next[i]};
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            busy       <= '0;
            busy_count <= '0;
        end else begin
            busy       <= busy_next;
            busy_count <= count_next;
        end
    end

endmodule

// File: rtl/register_bank.sv
// Multi-port register file with same-cycle write bypass and a busy table that
// tracks registers awaiting an in-flight result.
module register_bank
    import register_bank_pkg::*;
#(
    parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH     = DEFAULT_ADDR_WIDTH,
    parameter int NUM_READ_PORTS = DEFAULT_NUM_READ_PORTS,
    parameter int ZERO_REG       = 1,
    localparam int DEPTH         = 2**ADDR_WIDTH
) (
    input  logic            clock,
    input  logic            reset_n,
    register_bank_if.slave  bus
);

    localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = ADDR_WIDTH'(ZERO_REG_INDEX);

    logic [DATA_WIDTH-1:0]                regs [DEPTH];
    logic [DEPTH-1:0]                     busy;
    logic [NUM_READ_PORTS*DATA_WIDTH-1:0] rd_data;
    logic [NUM_READ_PORTS-1:0]            rd_ready;
    logic [ADDR_WIDTH-1:0]                rd_addr;
    logic                                 write_commit;

    assign write_commit = bus.write_enable &&
                          !((ZERO_REG != 0) && (bus.write_address == ZERO_ADDR));

    busy_table #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .ZERO_REG   (ZERO_REG)
    ) u_busy_table (
        .clock           (clock),
        .reset_n         (reset_n),
        .write_enable    (bus.write_enable),
        .write_address   (bus.write_address),
        .reserve_enable  (bus.reserve_enable),
        .reserve_address (bus.reserve_address),
        .flush           (bus.flush),
        .busy            (busy),
        .reserve_stall   (bus.reserve_stall),
        .busy_count      (bus.busy_count)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++)
                regs[i] <= '0;
        end else if (write_commit) begin
            regs[bus.write_address] <= bus.write_data;
        end
    end

    // Priority per port: zero register, then write bypass, then stored value.
    always_comb begin
        rd_data  = '0;
        rd_ready = '0;
        rd_addr  = '0;
        for (int p = 0; p < NUM_READ_PORTS; p++) begin
            rd_addr = bus.read_address[p*ADDR_WIDTH +: ADDR_WIDTH];
            if ((ZERO_REG != 0) && (rd_addr == ZERO_ADDR)) begin
                rd_data[p*DATA_WIDTH +: DATA_WIDTH] = '0;
                rd_ready[p]                         = 1'b1;
            end else if (bus.write_enable && (bus.write_address == rd_addr)) begin
                rd_data[p*DATA_WIDTH +: DATA_WIDTH] = bus.write_data;
                rd_ready[p]                         = 1'b1;
            end else begin
                rd_data[p*DATA_WIDTH +: DATA_WIDTH] = regs[rd_addr];
                rd_ready[p]                         = !busy[rd_addr];
            end
        end
    end

    assign bus.read_data  = rd_data;
    assign bus.read_ready = rd_ready;

endmodule

// File: tb/tb_register_bank.sv
// Directed test of register_bank against an array-based reference model,
// compared on every falling clock edge, plus hand-computed literal checks.
module tb_register_bank;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int NRP   = 2;
    localparam int DEPTH = 2**AW;

    logic clock = 1'b0;
    logic reset_n;

    register_bank_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_READ_PORTS(NRP)) bus ();

    register_bank #(
        .DATA_WIDTH     (DW),
        .ADDR_WIDTH     (AW),
        .NUM_READ_PORTS (NRP),
        .ZERO_REG       (1)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // ---------------- clock / reset ----------------
    always #5 clock = ~clock;

    // ---------------- scoreboard bookkeeping ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [DW-1:0] m_regs [DEPTH];
    bit            m_busy [DEPTH];
    logic [DW-1:0] exp_q [$];

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            m_regs[i] = '0;
            m_busy[i] = 1'b0;
        end
    end

    function automatic logic [AW-1:0] rd_addr_of(input int p);
        logic [NRP*AW-1:0] all;
        all = bus.read_address;
        return all[p*AW +: AW];
    endfunction

    function automatic logic [DW-1:0] dut_rd_data(input int p);
        logic [NRP*DW-1:0] all;
        all = bus.read_data;
        return all[p*DW +: DW];
    endfunction

    function automatic bit m_stall();
        return bus.reserve_enable && m_busy[bus.reserve_address] &&
               !(bus.write_enable && bus.write_address == bus.reserve_address);
    endfunction

    function automatic int m_count();
        int c = 0;
        for (int i = 0; i < DEPTH; i++) c += int'(m_busy[i]);
        return c;
    endfunction

    function automatic logic [DW-1:0] m_rd_data(input int p);
        logic [AW-1:0] a = rd_addr_of(p);
        if (a == 0) return '0;
        if (bus.write_enable && bus.write_address == a) return bus.write_data;
        return m_regs[a];
    endfunction

    function automatic bit m_rd_ready(input int p);
        logic [AW-1:0] a = rd_addr_of(p);
        if (a == 0) return 1'b1;
        if (bus.write_enable && bus.write_address == a) return 1'b1;
        return !m_busy[a];
    endfunction

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                m_regs[i] = '0;
                m_busy[i] = 1'b0;
            end
        end else begin
            bit accept;
            accept = bus.reserve_enable && !m_stall();
            if (bus.write_enable && bus.write_address != 0)
                m_regs[bus.write_address] = bus.write_data;
            if (bus.flush) begin
                for (int i = 0; i < DEPTH; i++) m_busy[i] = 1'b0;
            end else begin
                if (bus.write_enable) m_busy[bus.write_address] = 1'b0;
                if (accept && bus.reserve_address != 0) m_busy[bus.reserve_address] = 1'b1;
            end
        end
    end

    // Continuous compare on the falling edge, away from the active edge.
    always @(negedge clock) begin
        for (int p = 0; p < NRP; p++) begin
            check($sformatf("model rd_data p%0d", p), 64'(dut_rd_data(p)), 64'(m_rd_data(p)));
            check($sformatf("model rd_ready p%0d", p), 64'(bus.read_ready[p]), 64'(m_rd_ready(p)));
        end
        check("model reserve_stall", 64'(bus.reserve_stall), 64'(m_stall()));
        check("model busy_count", 64'(bus.busy_count), 64'(m_count()));
    end

    // ---------------- driver tasks ----------------
    task automatic idle();
        bus.write_enable    = 1'b0;
        bus.write_address   = '0;
        bus.write_data      = '0;
        bus.reserve_enable  = 1'b0;
        bus.reserve_address = '0;
        bus.flush           = 1'b0;
    endtask

    task automatic set_reads(input int a0, input int a1);
        bus.read_address = {AW'(a1), AW'(a0)};
    endtask

    task automatic drive_write(input int a, input logic [DW-1:0] d);
        bus.write_enable  = 1'b1;
        bus.write_address = AW'(a);
        bus.write_data    = d;
    endtask

    task automatic drive_reserve(input int a);
        bus.reserve_enable  = 1'b1;
        bus.reserve_address = AW'(a);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic mid();
        @(negedge clock);
        #1;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        reset_n = 1'b0;
        idle();
        set_reads(3, 7);
        exp_q.push_back(32'hDEADBEEF);
        exp_q.push_back(32'h0000_0055);
        exp_q.push_back(32'h0000_000A);
        exp_q.push_back(32'h0000_0077);
        tick();
        tick();
        reset_n = 1'b1;
        tick();

        // Reset state reads r3, r7.
        mid();
        check("reset rd p0", 64'(dut_rd_data(0)), 64'h0);
        check("reset rd p1", 64'(dut_rd_data(1)), 64'h0);
        check("reset ready", 64'(bus.read_ready), 64'h3);
        check("reset count", 64'(bus.busy_count), 64'h0);

        // Write bypass, then stored value, then write to r0 discarded.
        tick();
        set_reads(5, 0);
        drive_write(5, 32'hDEADBEEF);
        mid();
        check("bypass r5", 64'(dut_rd_data(0)), 64'(exp_q[0]));
        tick();
        idle();
        mid();
        check("stored r5", 64'(dut_rd_data(0)), 64'(exp_q[0]));
        tick();
        drive_write(0, 32'h1234);
        mid();
        check("r0 read during write", 64'(dut_rd_data(1)), 64'h0);
        tick();
        idle();
        mid();
        check("r0 after write", 64'(dut_rd_data(1)), 64'h0);

        // Reserve r9, re-reserve stalls, write releases.
        tick();
        set_reads(9, 5);
        drive_reserve(9);
        tick();
        idle();
        mid();
        check("r9 count", 64'(bus.busy_count), 64'h1);
        check("r9 not ready", 64'(bus.read_ready[0]), 64'h0);
        tick();
        drive_reserve(9);
        mid();
        check("r9 stall", 64'(bus.reserve_stall), 64'h1);
        tick();
        idle();
        mid();
        check("r9 count held", 64'(bus.busy_count), 64'h1);
        tick();
        drive_write(9, 32'h55);
        mid();
        check("r9 bypass ready", 64'(bus.read_ready[0]), 64'h1);
        tick();
        idle();
        mid();
        check("r9 released ready", 64'(bus.read_ready[0]), 64'h1);
        check("r9 released count", 64'(bus.busy_count), 64'h0);
        check("r9 value", 64'(dut_rd_data(0)), 64'(exp_q[1]));

        // Same-cycle write and re-reservation of busy r4.
        tick();
        set_reads(4, 9);
        drive_reserve(4);
        tick();
        idle();
        drive_write(4, 32'hA);
        drive_reserve(4);
        mid();
        check("r4 no stall", 64'(bus.reserve_stall), 64'h0);
        tick();
        idle();
        mid();
        check("r4 value", 64'(dut_rd_data(0)), 64'(exp_q[2]));
        check("r4 still busy", 64'(bus.read_ready[0]), 64'h0);
        check("r4 count", 64'(bus.busy_count), 64'h1);
        tick();
        drive_write(4, 32'hA);
        tick();
        idle();

        // Flush overrides reservation, write still commits.
        for (int r = 1; r <= 3; r++) begin
            drive_reserve(r);
            tick();
        end
        idle();
        mid();
        check("three busy", 64'(bus.busy_count), 64'h3);
        tick();
        bus.flush = 1'b1;
        drive_reserve(6);
        drive_write(2, 32'h77);
        tick();
        idle();
        set_reads(6, 2);
        mid();
        check("flush count", 64'(bus.busy_count), 64'h0);
        check("flush r6 ready", 64'(bus.read_ready[0]), 64'h1);
        check("flush r2 value", 64'(dut_rd_data(1)), 64'(exp_q[3]));

        // Zero-register reservation, top register, flush with write.
        tick();
        drive_reserve(0);
        mid();
        check("r0 reserve no stall", 64'(bus.reserve_stall), 64'h0);
        tick();
        idle();
        set_reads(0, 31);
        drive_reserve(31);
        mid();
        check("r0 reserve count", 64'(bus.busy_count), 64'h0);
        tick();
        idle();
        mid();
        check("r31 not ready", 64'(bus.read_ready[1]), 64'h0);
        check("r31 count", 64'(bus.busy_count), 64'h1);
        tick();
        drive_write(31, 32'h1);
        bus.flush = 1'b1;
        tick();
        idle();
        mid();
        check("r31 flushed count", 64'(bus.busy_count), 64'h0);
        check("r31 value", 64'(dut_rd_data(1)), 64'h1);

        // Asynchronous reset between edges with r8 busy.
        tick();
        set_reads(8, 5);
        drive_reserve(8);
        tick();
        idle();
        mid();
        check("r8 count", 64'(bus.busy_count), 64'h1);
        check("r8 not ready", 64'(bus.read_ready[0]), 64'h0);
        #1;
        reset_n = 1'b0;
        drive_reserve(8);
        #1;
        check("async count", 64'(bus.busy_count), 64'h0);
        check("async r8 ready", 64'(bus.read_ready[0]), 64'h1);
        check("async r8 data", 64'(dut_rd_data(0)), 64'h0);
        check("async r5 data", 64'(dut_rd_data(1)), 64'h0);
        check("async stall", 64'(bus.reserve_stall), 64'h0);
        idle();
        set_reads(8, 6);
        drive_write(6, 32'h99);
        tick();
        idle();
        reset_n = 1'b1;
        mid();
        check("reset drops write", 64'(dut_rd_data(1)), 64'h0);
        tick();
        drive_write(6, 32'h99);
        tick();
        idle();
        mid();
        check("post reset write", 64'(dut_rd_data(1)), 64'h99);
        check("post reset count", 64'(bus.busy_count), 64'h0);

        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
